// File: rtl/alu6.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu6 : registered two-operand ALU (add/sub/and/or) with Z/N/C/V flags     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module alu6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       m,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             out_valid
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  localparam int         MSB    = WIDTH - 1;

  logic [WIDTH-1:0] s_q, s_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             out_valid_q, out_valid_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] result;
  logic             carry_flag;
  logic             ovf_flag;

  // Shared adder: subtraction is a + ~b + 1, so the carry-in doubles as the sub select.
  always_comb begin
    is_sub  = (m == OP_SUB);
    b_op    = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  end

  always_comb begin
    result     = '0;
    carry_flag = 1'b0;
    ovf_flag   = 1'b0;
    case (m)
      OP_ADD: begin
        result     = sum_ext[WIDTH-1:0];
        carry_flag = sum_ext[WIDTH];
        ovf_flag   = (a[MSB] == b_op[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result     = sum_ext[WIDTH-1:0];
        // No carry out of a + ~b + 1 means a < b, i.e. a borrow.
        carry_flag = ~sum_ext[WIDTH];
        ovf_flag   = (a[MSB] == b_op[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  always_comb begin
    s_d         = s_q;
    z_d         = z_q;
    n_d         = n_q;
    c_d         = c_q;
    v_d         = v_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d = result;
      z_d = (result == '0);
      n_d = result[MSB];
      c_d = carry_flag;
      v_d = ovf_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      z_q         <= z_d;
      n_q         <= n_d;
      c_q         <= c_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign z         = z_q;
  assign n         = n_q;
  assign c         = c_q;
  assign v         = v_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu6.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu6 : directed self-checking bench for alu6                           |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_alu6;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       m;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             z;
  logic             n;
  logic             c;
  logic             v;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  alu6 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .m         (m),
    .in_valid  (in_valid),
    .s         (s),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [WIDTH-1:0] es,
                            input logic ez, input logic en, input logic ec,
                            input logic ev, input logic eov);
    checks++;
    assert (s === es) else begin
      errors++;
      $error("FAIL %s s observed=%b expected=%b", tag, s, es);
    end
    checks++;
    assert (z === ez) else begin
      errors++;
      $error("FAIL %s z observed=%b expected=%b", tag, z, ez);
    end
    checks++;
    assert (n === en) else begin
      errors++;
      $error("FAIL %s n observed=%b expected=%b", tag, n, en);
    end
    checks++;
    assert (c === ec) else begin
      errors++;
      $error("FAIL %s c observed=%b expected=%b", tag, c, ec);
    end
    checks++;
    assert (v === ev) else begin
      errors++;
      $error("FAIL %s v observed=%b expected=%b", tag, v, ev);
    end
    checks++;
    assert (out_valid === eov) else begin
      errors++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, eov);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    m        = 2'b00;
    step();
    step();
    expect_out("reset", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("idle_after_reset", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Group 1: all four opcodes back to back
    a = 6'b000110; b = 6'b001101; in_valid = 1'b1;
    m = 2'b00; step();
    expect_out("g1_add", 6'b010011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m = 2'b01; step();
    expect_out("g1_sub", 6'b111001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    m = 2'b10; step();
    expect_out("g1_and", 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m = 2'b11; step();
    expect_out("g1_or", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Group 2: signed overflow on add, borrow on sub
    a = 6'b010110; b = 6'b011101;
    m = 2'b00; step();
    expect_out("g2_add_ovf", 6'b110011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    m = 2'b01; step();
    expect_out("g2_sub", 6'b111001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Group 3: logic ops
    a = 6'b000110; b = 6'b011101;
    m = 2'b10; step();
    expect_out("g3_and", 6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m = 2'b11; step();
    expect_out("g3_or", 6'b011111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Wrap to zero on add, equal operands on sub
    a = 6'b111111; b = 6'b000001; m = 2'b00; step();
    expect_out("wrap_add", 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    a = 6'b100000; b = 6'b100000; m = 2'b01; step();
    expect_out("zero_sub", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Negative-overflow add: -32 + -1 wraps to +31
    a = 6'b100000; b = 6'b111111; m = 2'b00; step();
    expect_out("neg_ovf_add", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Hold: in_valid low, inputs wiggle, outputs frozen
    in_valid = 1'b0;
    a = 6'b101010; b = 6'b010101; m = 2'b00; step();
    expect_out("hold1", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    a = 6'b111111; b = 6'b111111; m = 2'b01; step();
    expect_out("hold2", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    a = 6'b000000; b = 6'b000000; m = 2'b11; step();
    expect_out("hold3", 6'b011111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with an operation in flight
    a = 6'b000110; b = 6'b001101; m = 2'b11; in_valid = 1'b1; step();
    expect_out("pre_reset_or", 6'b001111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    a = 6'b010110; b = 6'b011101; m = 2'b00;
    #2 rst = 1'b1;
    #1;
    expect_out("async_reset_now", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("reset_held_edge", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    in_valid = 1'b0;
    step();
    expect_out("after_reset_release", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
